// File: rtl/button_debouncer.sv
// Debounces a raw button pin into a clean level with press, release and
// long-press strobes; a two-flop synchronizer guards the asynchronous pin.
module button_debouncer #(
   parameter int   DEBOUNCE_BITS = 16,
   parameter int   LONG_BITS     = 24,
   parameter logic INVERT        = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_hold
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DOWN = 2'd1,
      LONG = 2'd2
   } state_t;

   localparam logic [DEBOUNCE_BITS-1:0] DCTR_MAX  = '1;
   localparam logic [LONG_BITS-1:0]     LCTR_MAX  = '1;
   localparam logic [LONG_BITS-1:0]     LCTR_TERM = {{(LONG_BITS-1){1'b1}}, 1'b0};

   logic                     sync1_q, sync1_d;
   logic                     sync2_q, sync2_d;
   logic [DEBOUNCE_BITS-1:0] dctr_q, dctr_d;
   logic [LONG_BITS-1:0]     lctr_q, lctr_d;
   logic                     level_q, level_d;
   logic                     press_q, press_d;
   logic                     release_q, release_d;
   logic                     long_q, long_d;
   state_t                   state_q, state_d;

   logic sample;
   logic accept;
   logic rise;
   logic fall;

   always_comb begin
      sync1_d   = i_btn;
      sync2_d   = sync1_q;
      sample    = sync2_q ^ INVERT;
      accept    = (sample != level_q) && (dctr_q == DCTR_MAX);
      rise      = accept && sample;
      fall      = accept && !sample;

      dctr_d    = '0;
      if ((sample != level_q) && (dctr_q != DCTR_MAX)) begin
         dctr_d = dctr_q + 1'b1;
      end
      level_d   = accept ? sample : level_q;
      press_d   = rise;
      release_d = fall;
      long_d    = 1'b0;
      state_d   = state_q;
      lctr_d    = lctr_q;

      case (state_q)
         IDLE: begin
            if (rise) state_d = DOWN;
         end
         DOWN: begin
            if (fall) begin
               state_d = IDLE;
            end else begin
               if (lctr_q != LCTR_MAX) lctr_d = lctr_q + 1'b1;
               if (lctr_q == LCTR_TERM) begin
                  long_d  = 1'b1;
                  state_d = LONG;
               end
            end
         end
         LONG: begin
            if (fall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A release on the terminal-count edge suppresses the long event above
      // and must also leave the hold counter cleared.
      if (!level_q || rise || fall) lctr_d = '0;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1_q   <= INVERT;
         sync2_q   <= INVERT;
         dctr_q    <= '0;
         lctr_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         state_q   <= IDLE;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         dctr_q    <= dctr_d;
         lctr_q    <= lctr_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         state_q   <= state_d;
      end
   end

   assign o_level   = level_q;
   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_long    = long_q;
   assign o_hold    = (state_q == LONG);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: small counters (2-bit debounce,
// 4-bit hold) so every latency is a short, hand-counted number of edges.
module tb_button_debouncer;

   logic clk = 1'b0;
   logic rst_n;
   logic btn0, btn1;
   logic level0, press0, release0, long0, hold0;
   logic level1, press1, release1, long1, hold1;

   int tests_run = 0;
   int tests_failed = 0;
   int n_press, n_release, n_long;

   always #5 clk = ~clk;

   button_debouncer #(.DEBOUNCE_BITS(2), .LONG_BITS(4), .INVERT(1'b0)) u_dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn0),
      .o_level(level0), .o_press(press0), .o_release(release0),
      .o_long(long0), .o_hold(hold0)
   );

   button_debouncer #(.DEBOUNCE_BITS(2), .LONG_BITS(4), .INVERT(1'b1)) u_dut_inv (
      .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn1),
      .o_level(level1), .o_press(press1), .o_release(release1),
      .o_long(long1), .o_hold(hold1)
   );

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One active edge, then settle; strobes of the normal-polarity DUT are tallied.
   task automatic tick();
      @(posedge clk);
      #1;
      if (press0)   n_press++;
      if (release0) n_release++;
      if (long0)    n_long++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clr();
      n_press = 0;
      n_release = 0;
      n_long = 0;
   endtask

   // Drive a press and stop on the edge that accepts it (6 edges).
   task automatic press_and_accept(input string tag);
      btn0 = 1'b1;
      run(5);
      check({tag, "_lvl_pre"}, level0, 0);
      tick();
      check({tag, "_press"}, press0, 1);
      check({tag, "_lvl"}, level0, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      btn0  = 1'b0;
      btn1  = 1'b1;
      clr();

      // T1: reset, then idle
      run(5);
      check("rst_level", level0, 0);
      check("rst_hold", hold0, 0);
      check("rst_strobes", {press0, release0, long0}, 0);
      rst_n = 1'b1;
      clr();
      run(50);
      check("idle_level", level0, 0);
      check("idle_strobes", n_press + n_release + n_long, 0);
      check("idle_inv_level", level1, 0);

      // T2: clean press, long event, sustained hold
      press_and_accept("t2");
      check("t2_long_at_press", long0, 0);
      clr();
      tick();
      check("t2_press_width", press0, 0);
      run(13);
      check("t2_no_early_long", n_long, 0);
      check("t2_hold_pre", hold0, 0);
      tick();
      check("t2_long", long0, 1);
      check("t2_hold", hold0, 1);
      check("t2_press_long_excl", press0, 0);
      clr();
      run(100);
      check("t2_single_long", n_long, 0);
      check("t2_hold_kept", hold0, 1);
      btn0 = 1'b0;
      run(5);
      check("t2_lvl_pre_rel", level0, 1);
      tick();
      check("t2_release", release0, 1);
      check("t2_hold_after_rel", hold0, 0);
      run(10);

      // T3: short glitch and bouncing
      clr();
      btn0 = 1'b1;
      run(3);
      btn0 = 1'b0;
      run(20);
      check("t3_glitch_press", n_press, 0);
      check("t3_glitch_level", level0, 0);
      for (int i = 0; i < 10; i++) begin
         btn0 = ~btn0;
         run(2);
      end
      check("t3_bounce_press", n_press, 0);
      check("t3_bounce_level", level0, 0);
      press_and_accept("t3");
      clr();
      run(3);
      check("t3_one_press", n_press, 0);
      btn0 = 1'b0;
      run(20);

      // T4: release before long; second press restarts the hold count
      clr();
      press_and_accept("t4a");
      run(5);
      btn0 = 1'b0;
      run(5);
      check("t4_lvl_pre_rel", level0, 1);
      tick();
      check("t4_release", release0, 1);
      check("t4_rel_level", level0, 0);
      check("t4_rel_hold", hold0, 0);
      check("t4_no_long", n_long, 0);
      run(10);
      press_and_accept("t4b");
      clr();
      run(14);
      check("t4_no_early_long", n_long, 0);
      tick();
      check("t4_long", long0, 1);
      btn0 = 1'b0;
      run(20);

      // T5: asynchronous reset while in LONG, button still held
      press_and_accept("t5a");
      run(15);
      check("t5_hold_before", hold0, 1);
      run(3);
      #3;
      rst_n = 1'b0;
      #1;
      check("t5_async_level", level0, 0);
      check("t5_async_hold", hold0, 0);
      check("t5_async_strobes", {press0, release0, long0}, 0);
      run(2);
      rst_n = 1'b1;
      btn0 = 1'b1;
      run(5);
      check("t5_lvl_pre", level0, 0);
      tick();
      check("t5_press", press0, 1);
      clr();
      run(14);
      check("t5_no_early_long", n_long, 0);
      tick();
      check("t5_long", long0, 1);
      btn0 = 1'b0;
      run(20);

      // T6: active-low input
      check("t6_idle_level", level1, 0);
      btn1 = 1'b0;
      run(5);
      check("t6_lvl_pre", level1, 0);
      tick();
      check("t6_press", press1, 1);
      check("t6_level", level1, 1);
      btn1 = 1'b1;
      run(5);
      check("t6_lvl_pre_rel", level1, 1);
      tick();
      check("t6_release", release1, 1);
      check("t6_rel_level", level1, 0);

      // T7: release accepted on the same edge as the long terminal count
      run(10);
      clr();
      press_and_accept("t7");
      run(9);
      btn0 = 1'b0;
      run(5);
      check("t7_lvl_pre", level0, 1);
      tick();
      check("t7_release", release0, 1);
      check("t7_long_suppressed", long0, 0);
      check("t7_hold", hold0, 0);
      run(20);
      check("t7_no_late_long", n_long, 0);
      check("t7_level", level0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
